result_display: RTL
===================

RESULT_DISPLAY -- requirements
Module: result_display

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 50000, clk cycles each digit is shown (legal range 2..2^20).
REQ-002 SHALL have parameter BLANK_LZ, default 1, where 1 enables leading-zero blanking.
REQ-003 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port finish  input  1  completion flag from bpnetwork; level or pulse.
REQ-006 SHALL have port result  input  32  bpnetwork output word; sampled only at capture.
REQ-007 SHALL have port valid  output  1  high once a result has been captured.
REQ-008 SHALL have port an  output  8  digit enables, active-low, one-hot; an[0] is the least-significant nibble.
REQ-009 SHALL have port seg  output  8  segments, active-low; seg[6:0]=gfedcba, seg[7]=dp.

Function
REQ-010 SHALL register finish into finish_d; capture event = finish & ~finish_d.
REQ-011 SHALL load result into result_q and set valid=1 on the same clk edge as the capture event.
REQ-012 SHALL ignore result while finish stays high after the capture edge; a new capture needs finish to go low and then high again.
REQ-013 SHALL overwrite result_q on every later capture event; valid stays 1.
REQ-014 SHALL run a prescaler 0..SCAN_DIV-1; at terminal count, prescaler wraps to 0 and digit index (3 bits) increments, wrapping 7 to 0.
REQ-015 SHALL register an and seg, one cycle after the index/result_q they reflect; both change on the same edge.
REQ-016 SHALL drive an = ~(8'b1 << index) while out of reset.
REQ-017 SHALL, while valid=0, drive every digit as a dash, seg=8'hBF.
REQ-018 SHALL, while valid=1, drive hex glyph of nibble result_q[4*index+3 : 4*index].
REQ-019 SHALL, with BLANK_LZ=1, blank digit i>0 (seg=8'hFF) when all nibbles i..7 are zero; digit 0 is never blanked.
REQ-020 SHALL hold seg[7]=1 (dp off) at all times.
REQ-021 SHALL, when capture and prescaler terminal coincide, show the new index with the new result_q one cycle later, never a mixed old/new frame.
REQ-022 SHALL use glyphs (active-low, dp=1): 0=C0 1=F9 2=A4 3=B0 4=99 5=92 6=82 7=F8 8=80 9=90 A=88 b=83 C=C6 d=A1 E=86 F=8E.

Reset
REQ-023 SHALL, on rst=1 at a clk edge, set result_q=0, valid=0, finish_d=0, prescaler=0, index=0, an=8'hFF, seg=8'hFF.
REQ-024 SHALL, with rst held high, keep those values regardless of finish.
REQ-025 SHALL treat rst asserted mid-scan or mid-capture the same way; the first digit shown after release is index 0 with a dash.

Structure
REQ-026 SHALL hold DIGITS=8, the glyph table, DASH=8'hBF and BLANK=8'hFF as constants in shared file result_display_pkg.
REQ-027 SHALL contain one combinational sub-module hex7seg (4-bit nibble in, 8-bit active-low segments out); everything else stays in result_display.

Verification (bench uses SCAN_DIV=4)
REQ-028 SHALL verify reset: rst=1 for 2 cycles, finish=1 -> an=FF, seg=FF, valid=0.
REQ-029 SHALL verify idle scan: release rst, finish=0 -> seg=BF; an steps FE,FD,FB,...,7F every 4 cycles, then back to FE.
REQ-030 SHALL verify capture: result=32'h1234ABCD, finish pulsed 1 cycle -> valid=1 next edge; an=FE/seg=A1, an=FD/seg=C6, an=7F/seg=F9.
REQ-031 SHALL verify blanking: result=32'h000000A5 -> digit0 seg=92, digit1 seg=88, digits 2..7 seg=FF; result=0 -> digit0 seg=C0, rest FF.
REQ-032 SHALL verify held finish: finish high 20 cycles, result changes 1111_1111 -> 2222_2222 on cycle 5 -> displayed word stays 1111_1111.
REQ-033 SHALL verify reset mid-run: valid=1, index=5, rst for 1 cycle -> an=FF, seg=FF, valid=0; after release, an=FE and seg=BF.

Source files
------------

// File: rtl/result_display_pkg.sv
// Shared constants for the 8-digit hex result display: digit count,
// active-low seven-segment glyphs and the dash/blank patterns.
package result_display_pkg;

    localparam int DIGITS = 8;
    localparam int IDX_W  = 3;

    localparam logic [7:0] DASH  = 8'hBF;
    localparam logic [7:0] BLANK = 8'hFF;

    // Packed array: the leftmost entry is glyph F, the rightmost is glyph 0.
    localparam logic [15:0][7:0] GLYPHS = {
        8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80,
        8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
    };

endpackage

// File: rtl/result_display_hex7seg.sv
// Combinational nibble-to-glyph decoder; outputs are active-low with dp off.
module hex7seg
    import result_display_pkg::*;
(
    input  logic [3:0] i_nibble,
    output logic [7:0] o_seg
);

    assign o_seg = GLYPHS[i_nibble];

endmodule

// File: rtl/result_display.sv
// Captures a bpnetwork result on the rising edge of finish and scans it
// across eight multiplexed seven-segment digits as hex.
module result_display
    import result_display_pkg::*;
#(
    parameter int SCAN_DIV = 50000,
    parameter int BLANK_LZ = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        finish,
    input  logic [31:0] result,
    output logic        valid,
    output logic [7:0]  an,
    output logic [7:0]  seg
);

    localparam int            PW   = $clog2(SCAN_DIV);
    localparam logic [PW-1:0] LAST = PW'(SCAN_DIV - 1);

    logic              r_finishD;
    logic [31:0]       r_resultQ;
    logic              r_valid;
    logic [PW-1:0]     r_prescaler;
    logic [IDX_W-1:0]  r_index;
    logic [7:0]        r_an;
    logic [7:0]        r_seg;

    logic              w_capture;
    logic [3:0]        w_nibble;
    logic [7:0]        w_glyph;
    logic [DIGITS-1:0] w_tailZero;
    logic              w_blank;
    logic [7:0]        w_segNext;

    assign w_capture = finish & ~r_finishD;
    assign w_nibble  = r_resultQ[4*r_index +: 4];

    // Digit i is a leading zero when it and every more-significant nibble are zero.
    always_comb begin
        w_tailZero = '0;
        for (int i = 0; i < DIGITS; i++) begin
            w_tailZero[i] = ((r_resultQ >> (4 * i)) == 32'h0);
        end
    end

    assign w_blank = (BLANK_LZ != 0) && (r_index != '0) && w_tailZero[r_index];

    hex7seg u_hex7seg (
        .i_nibble (w_nibble),
        .o_seg    (w_glyph)
    );

    always_comb begin
        w_segNext = DASH;
        if (r_valid) begin
            w_segNext = w_blank ? BLANK : w_glyph;
        end
    end

    // an/seg are computed from already-registered index and result, so a
    // capture coinciding with a digit step can never produce a mixed frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_finishD   <= 1'b0;
            r_resultQ   <= '0;
            r_valid     <= 1'b0;
            r_prescaler <= '0;
            r_index     <= '0;
            r_an        <= 8'hFF;
            r_seg       <= BLANK;
        end else begin
            r_finishD <= finish;
            if (w_capture) begin
                r_resultQ <= result;
                r_valid   <= 1'b1;
            end
            if (r_prescaler == LAST) begin
                r_prescaler <= '0;
                r_index     <= r_index + IDX_W'(1);
            end else begin
                r_prescaler <= r_prescaler + PW'(1);
            end
            r_an  <= ~(8'h01 << r_index);
            r_seg <= w_segNext;
        end
    end

    assign valid = r_valid;
    assign an    = r_an;
    assign seg   = r_seg;

endmodule
